// File: rtl/alu_mc_if.sv
// Handshake and data bundle between the EX-stage control and the multi-cycle ALU.
// The master drives operations and consumes results; the ALU is the slave.
interface alu_mc_if #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_SIZE-1:0]   sel;
  logic [WORD_SIZE-1:0] data_1;
  logic [WORD_SIZE-1:0] data_2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_zero_flag;
  logic                 alu_oflow;
  logic                 div_by_zero;

  modport master (
    output in_valid, sel, data_1, data_2, out_ready,
    input  in_ready, out_valid, alu_out, alu_zero_flag, alu_oflow, div_by_zero
  );

  modport slave (
    input  in_valid, sel, data_1, data_2, out_ready,
    output in_ready, out_valid, alu_out, alu_zero_flag, alu_oflow, div_by_zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIVU/REMU, behind a valid/ready handshake with held results.
module alu_mc #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4,
  parameter int CNT_W     = 5
) (
  input logic   clk,
  input logic   rst,
  alu_mc_if.slave bus
);
  localparam int W = WORD_SIZE;

  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(4'b0101);
  localparam logic [OP_SIZE-1:0] OP_OR   = OP_SIZE'(4'b0110);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'b0111);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(4'b1000);
  localparam logic [OP_SIZE-1:0] OP_SLT  = OP_SIZE'(4'b1001);
  localparam logic [OP_SIZE-1:0] OP_MUL  = OP_SIZE'(4'b1101);
  localparam logic [OP_SIZE-1:0] OP_DIVU = OP_SIZE'(4'b1110);
  localparam logic [OP_SIZE-1:0] OP_REMU = OP_SIZE'(4'b1111);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             r_state;
  logic [OP_SIZE-1:0] r_sel;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [2*W-1:0]     r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_out;
  logic               r_oflow;
  logic               r_dbz;
  logic               r_out_valid;

  logic               w_accept;
  logic [W-1:0]       w_add;
  logic [W-1:0]       w_sub;
  logic [W-1:0]       w_sc_out;
  logic               w_sc_oflow;
  logic               w_sc_dbz;
  logic               w_sc_multi;
  logic [W:0]         w_mul_sum;
  logic [2*W-1:0]     w_mul_next;
  logic [W:0]         w_div_rem_sh;
  logic [W-1:0]       w_div_diff;
  logic               w_div_ge;
  logic [2*W-1:0]     w_div_next;

  assign bus.in_ready      = (r_state == S_IDLE);
  assign bus.out_valid     = r_out_valid;
  assign bus.alu_out       = r_out;
  assign bus.alu_zero_flag = (r_out == {W{1'b0}});
  assign bus.alu_oflow     = r_oflow;
  assign bus.div_by_zero   = r_dbz;
  assign w_accept          = bus.in_valid & (r_state == S_IDLE);

  // Result of the single-cycle ops, evaluated straight from the input operands
  always_comb begin
    w_add      = bus.data_1 + bus.data_2;
    w_sub      = bus.data_1 - bus.data_2;
    w_sc_out   = {W{1'b0}};
    w_sc_oflow = 1'b0;
    w_sc_dbz   = 1'b0;
    w_sc_multi = 1'b0;
    case (bus.sel)
      OP_AND: w_sc_out = bus.data_1 & bus.data_2;
      OP_OR:  w_sc_out = bus.data_1 | bus.data_2;
      OP_ADD: begin
        w_sc_out   = w_add;
        w_sc_oflow = (bus.data_1[W-1] == bus.data_2[W-1]) && (w_add[W-1] != bus.data_1[W-1]);
      end
      OP_SUB: begin
        w_sc_out   = w_sub;
        w_sc_oflow = (bus.data_1[W-1] != bus.data_2[W-1]) && (w_sub[W-1] != bus.data_1[W-1]);
      end
      OP_SLT: w_sc_out = {{(W-1){1'b0}}, ($signed(bus.data_1) < $signed(bus.data_2))};
      OP_MUL: w_sc_multi = 1'b1;
      OP_DIVU, OP_REMU: begin
        // Divide by zero short-circuits: quotient all-ones, remainder = dividend
        if (bus.data_2 == {W{1'b0}}) begin
          w_sc_out = (bus.sel == OP_DIVU) ? {W{1'b1}} : bus.data_1;
          w_sc_dbz = 1'b1;
        end else begin
          w_sc_multi = 1'b1;
        end
      end
      default: w_sc_out = {W{1'b0}};
    endcase
  end

  // One shift-add multiply step and one restoring-divide step on r_acc
  always_comb begin
    w_mul_sum    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    w_mul_next   = {w_mul_sum, r_acc[W-1:1]};
    w_div_rem_sh = {r_acc[2*W-1:W], r_acc[W-1]};
    w_div_diff   = w_div_rem_sh[W-1:0] - r_b;
    w_div_ge     = (w_div_rem_sh >= {1'b0, r_b});
    if (w_div_ge) begin
      w_div_next = {w_div_diff, r_acc[W-2:0], 1'b1};
    end else begin
      w_div_next = {w_div_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
    end
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= {OP_SIZE{1'b0}};
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_acc       <= {(2*W){1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out       <= {W{1'b0}};
      r_oflow     <= 1'b0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sel <= bus.sel;
            r_a   <= bus.data_1;
            r_b   <= bus.data_2;
            r_cnt <= {CNT_W{1'b0}};
            if (w_sc_multi) begin
              // MUL keeps the multiplier in the low half; DIV keeps the dividend there
              r_acc   <= (bus.sel == OP_MUL) ? {{W{1'b0}}, bus.data_2} : {{W{1'b0}}, bus.data_1};
              r_state <= S_CALC;
            end else begin
              r_out       <= w_sc_out;
              r_oflow     <= w_sc_oflow;
              r_dbz       <= w_sc_dbz;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= (r_sel == OP_MUL) ? w_mul_next : w_div_next;
          if (r_cnt == CNT_W'(W-1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_dbz       <= 1'b0;
            if (r_sel == OP_MUL) begin
              r_out   <= w_mul_next[W-1:0];
              r_oflow <= |w_mul_next[2*W-1:W];
            end else if (r_sel == OP_DIVU) begin
              r_out   <= w_div_next[W-1:0];
              r_oflow <= 1'b0;
            end else begin
              r_out   <= w_div_next[2*W-1:W];
              r_oflow <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
